// File: rtl/wdg_pkg.sv
// Shared definitions for the watchdog controller slice.
package wdg_pkg;

    typedef enum logic [1:0] {
        WDG_IDLE  = 2'd0,
        WDG_ARMED = 2'd1,
        WDG_WARN  = 2'd2,
        WDG_BITE  = 2'd3
    } wdg_state_e;

    localparam logic [7:0]  WDG_KICK_KEY   = 8'h5A;
    localparam int unsigned WDG_RST_CYCLES = 16;

endpackage

// File: rtl/wdg_pulse_stretch.sv
// Load-and-count-down pulse generator: pulse is high for exactly CYCLES cycles
// starting the cycle after load; last marks the final high cycle.
module wdg_pulse_stretch
    import wdg_pkg::*;
#(
    parameter int unsigned CYCLES = WDG_RST_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic pulse,
    output logic last
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Count down from CYCLES after a load; pulse drops after the cycle where cnt_q==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pulse <= 1'b0;
        end else if (load) begin
            cnt_q <= CW'(CYCLES);
            pulse <= 1'b1;
        end else begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            pulse <= (cnt_q > CW'(1));
        end
    end

    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/wdg_ctrl.sv
// Watchdog controller: expiry detection, warn/bite FSM, keyed kick handshake
// and counter reload pulse generation.
module wdg_ctrl
    import wdg_pkg::*;
#(
    parameter int unsigned           WIDTH      = 4,
    parameter int unsigned           KEY_WIDTH  = 8,
    parameter logic [KEY_WIDTH-1:0]  KICK_KEY   = KEY_WIDTH'(WDG_KICK_KEY),
    parameter int unsigned           RST_CYCLES = WDG_RST_CYCLES,
    parameter bit                    LOCKABLE   = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 res_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     count_wdg,
    input  logic                 cnt_tick,
    input  logic                 kick_valid,
    input  logic [KEY_WIDTH-1:0] kick_key,
    output logic                 kick_ready,
    output logic                 cnt_rst_n,
    output logic                 irq,
    output logic                 rst_req,
    output logic                 key_err,
    output logic [1:0]           state
);

    wdg_state_e state_q, state_d;
    logic       lock_q, lock_d;
    logic       irq_d, key_err_d, cnt_rst_n_d;
    logic       bite_load, bite_last;
    logic       expiry, kick_ok, kick_bad;

    assign expiry     = cnt_tick && (count_wdg == '0);
    assign kick_ready = (state_q != WDG_BITE);
    assign kick_ok    = kick_valid && kick_ready && (kick_key == KICK_KEY);
    assign kick_bad   = kick_valid && kick_ready && (kick_key != KICK_KEY);
    assign state      = state_q;

    // State register plus registered outputs and lock flag.
    always_ff @(posedge sys_clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= WDG_IDLE;
            lock_q    <= 1'b0;
            irq       <= 1'b0;
            key_err   <= 1'b0;
            cnt_rst_n <= 1'b1;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            irq       <= irq_d;
            key_err   <= key_err_d;
            cnt_rst_n <= cnt_rst_n_d;
        end
    end

    // Next-state decode; priority bad kick > good kick > expiry > en deassert.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WDG_IDLE: begin
                if (en) state_d = WDG_ARMED;
            end
            WDG_ARMED: begin
                if (kick_bad)              state_d = WDG_BITE;
                else if (kick_ok)          state_d = WDG_ARMED;
                else if (expiry)           state_d = WDG_WARN;
                else if (!en && !lock_q)   state_d = WDG_IDLE;
            end
            WDG_WARN: begin
                if (kick_bad)              state_d = WDG_BITE;
                else if (kick_ok)          state_d = WDG_ARMED;
                else if (expiry)           state_d = WDG_BITE;
                else if (!en && !lock_q)   state_d = WDG_IDLE;
            end
            WDG_BITE: begin
                if (bite_last) state_d = WDG_IDLE;
            end
            default: state_d = WDG_IDLE;
        endcase
    end

    // Next values of the registered outputs, lock and bite-timer load.
    always_comb begin
        lock_d      = lock_q;
        key_err_d   = key_err;
        cnt_rst_n_d = 1'b1;
        case (state_q)
            WDG_IDLE: begin
                if (en) begin
                    cnt_rst_n_d = 1'b0;
                    if (LOCKABLE) lock_d = 1'b1;
                end
            end
            WDG_ARMED, WDG_WARN: begin
                if (kick_bad)     key_err_d   = 1'b1;
                else if (kick_ok) cnt_rst_n_d = 1'b0;
            end
            WDG_BITE: begin
                if (bite_last) begin
                    cnt_rst_n_d = 1'b0;
                    lock_d      = 1'b0;
                end
            end
            default: ;
        endcase
        // irq is raised on entry to WARN and simply held through BITE.
        irq_d     = (state_d == WDG_WARN) || ((state_d == WDG_BITE) && irq);
        bite_load = (state_q != WDG_BITE) && (state_d == WDG_BITE);
    end

    wdg_pulse_stretch #(
        .CYCLES (RST_CYCLES)
    ) u_bite_timer (
        .clk   (sys_clk),
        .rst_n (res_n),
        .load  (bite_load),
        .pulse (rst_req),
        .last  (bite_last)
    );

endmodule
